rr_lock_arbiter: RTL and testbench
==================================

# rr_lock_arbiter

Round-robin lock arbiter that shares one multi-cycle resource between N requesters. A grant is held until the owner signals `done`, drops its request, or a hold limit expires. The next owner is then chosen with rotating priority, starting after the previous owner. It sits between the requesting agents and the shared resource, and builds on the single-cycle round-robin arbitration already used in the design.

## Interface
Parameters:
- `N` — default 4 — number of requesters; legal range 2..16.
- `MAX_HOLD` — default 16 — maximum number of consecutive cycles one owner may hold the grant; must be ≥1.

Ports:
- `clk` — input — 1 — single clock; all logic on the rising edge.
- `rst` — input — 1 — synchronous, active-high reset.
- `req` — input — N — per-requester request level.
- `done` — input — N — per-requester release pulse; only the bit of the current owner is honoured.
- `gnt` — output — N — registered one-hot grant, or all zeros.
- `gnt_id` — output — $clog2(N) — index of the current owner; valid while `busy`=1.
- `busy` — output — 1 — registered; equals |gnt.
- `timeout` — output — 1 — one-cycle pulse, registered, on a forced release at the hold limit.

## Operation
- State machine `IDLE` / `OWNED`, with a rotate pointer `ptr` (range 0..N-1).
- Winner selection (combinational): scan `req` from `ptr` upward, wrapping modulo N; the first set bit wins.
- **`IDLE`**
  - If `req`≠0: load `gnt`/`gnt_id` with the winner, clear the hold counter, go to `OWNED`.
  - Otherwise stay in `IDLE`.
- **`OWNED`** — the release condition is the first true of:
  - `done[gnt_id]`;
  - `!req[gnt_id]`;
  - hold counter = MAX_HOLD-1 (pulse `timeout` only if neither of the other two is true).
- **On release:**
  - Set `ptr` = (gnt_id+1) mod N.
  - Evaluate the winner in the same cycle using the new `ptr`. The released owner has lowest priority but stays eligible if it is still requesting.
  - If there is a winner, hand over at the same edge with zero bubble and reset the counter. Otherwise clear `gnt` and go to `IDLE`.
- **Without release:** increment the hold counter; `gnt` is unchanged.
- Changes to `req` while `OWNED` never preempt the owner.
- `done` bits from non-owners are ignored.
- Hold counter width: $clog2(MAX_HOLD). It never exceeds MAX_HOLD-1.
- With MAX_HOLD=1, every grant lasts exactly one cycle, so the arbiter behaves as a plain round-robin arbiter.

## Timing
- **Reset values:** `gnt`=0, `gnt_id`=0, `busy`=0, `timeout`=0, `ptr`=0, state `IDLE`, counter 0.
- **Reset mid-grant:** `gnt` is cleared at the reset edge, with no `timeout` pulse.
- **Grant latency:** `req` sampled at edge k drives `gnt` high from edge k onward, visible in cycle k+1. There is one cycle from request to grant.
- **Release:** `done` sampled at edge k means `gnt` changes at edge k. The owner therefore holds the grant in the cycle in which it asserts `done`.
- **Hold limit:** the grant lasts exactly MAX_HOLD cycles when there is no early release.
- **`timeout`:** asserted in the cycle after the last held cycle, coincident with the new `gnt`.
- **Simultaneous `done` and limit:** treated as a normal release; no `timeout`.
- **`req` all zero after release:** `busy` falls at the release edge.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Package `rr_lock_pkg`:
  - state enum `arb_state_t` {IDLE, OWNED};
  - function `rr_winner(req, ptr)`, returning a valid flag and an index.
- Sub-module `rr_pick`:
  - combinational rotate-priority picker, parameter N;
  - inputs `req`, `ptr`; outputs `valid`, `idx`;
  - instantiated once.
- Top level: FSM, hold counter, `ptr` register, output registers.

## Test plan
- **Reset then idle:** `rst`=1 for 2 cycles, `req`=0 → `gnt`=0000, `busy`=0, `timeout`=0 throughout.
- **Single owner:** `req`=0010 held, `done[1]` pulsed in the 3rd granted cycle → `gnt`=0010 for exactly 3 cycles, then 0000.
- **Rotation with zero-bubble handoff:** `req`=1111 held, each owner pulses `done` in its 1st granted cycle → `gnt` sequence 0001, 0010, 0100, 1000, 0001 on consecutive cycles.
- **Hold limit:** MAX_HOLD=4, `req`=0101, no `done` → `gnt`=0001 for 4 cycles, then 0100 with `timeout`=1 for one cycle, then 0100 for 4 cycles.
- **Non-owner `done` and request drop:** `gnt`=0100, `done`=1011 → no change; `req[2]` drops → `gnt` moves to 1000 when `req[3]`=1.
- **Reset mid-grant:** `gnt`=1000 at hold count 2, `rst`=1 → next cycle `gnt`=0000 and `timeout`=0. After reset with `req`=1111, the first grant is 0001.

Source files
------------

// File: rtl/rr_lock_pkg.sv
// Shared types and the rotate-priority winner function for the round-robin lock arbiter.
package rr_lock_pkg;

  localparam int unsigned MAX_N = 16;
  localparam int unsigned IDX_W = 4;

  typedef enum logic {IDLE, OWNED} arb_state_t;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } pick_t;

  // First set bit of req scanning upward from ptr, wrapping modulo n.
  function automatic pick_t rr_winner(input logic [MAX_N-1:0] req,
                                      input logic [IDX_W-1:0] ptr,
                                      input int unsigned      n);
    pick_t       p;
    int unsigned j;
    p = '0;
    for (int unsigned i = 0; i < MAX_N; i++) begin
      if (i < n) begin
        j = (32'(ptr) + i) % n;
        if (!p.valid && req[j[IDX_W-1:0]]) begin
          p.valid = 1'b1;
          p.idx   = j[IDX_W-1:0];
        end
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotate-priority picker: lowest index at or above ptr (mod N) wins.
module rr_pick
  import rr_lock_pkg::*;
#(
  parameter  int unsigned N  = 4,
  localparam int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          valid,
  output logic [IW-1:0] idx
);

  pick_t p;
  logic  unused_pick;

  always_comb p = rr_winner(MAX_N'(req), IDX_W'(ptr), N);

  assign valid       = p.valid;
  assign idx         = p.idx[IW-1:0];
  assign unused_pick = ^p.idx;

endmodule

// File: rtl/rr_lock_arbiter.sv
// Round-robin lock arbiter: grant held until done, request drop or hold limit,
// then handed over with rotating priority and no idle bubble.
module rr_lock_arbiter
  import rr_lock_pkg::*;
#(
  parameter  int unsigned N        = 4,
  parameter  int unsigned MAX_HOLD = 16,
  localparam int unsigned IW       = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  done,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_id,
  output logic          busy,
  output logic          timeout
);

  localparam int unsigned CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);
  localparam logic [IW-1:0] ID_LAST   = IW'(N - 1);

  arb_state_t    state, state_n;
  logic [IW-1:0] ptr, ptr_n, ptr_inc, pick_ptr, gnt_id_n, pick_idx;
  logic [CW-1:0] cnt, cnt_n;
  logic [N-1:0]  gnt_n;
  logic          busy_n, timeout_n, pick_valid;
  logic          owner_done, owner_drop, at_limit, release_c;

  rr_pick #(.N(N)) u_pick (
    .req   (req),
    .ptr   (pick_ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // Release conditions for the current owner
  always_comb begin
    owner_done = done[gnt_id];
    owner_drop = !req[gnt_id];
    at_limit   = (cnt == HOLD_LAST);
    release_c  = (state == OWNED) && (owner_done || owner_drop || at_limit);
    ptr_inc    = (gnt_id == ID_LAST) ? '0 : gnt_id + IW'(1);
    pick_ptr   = release_c ? ptr_inc : ptr;
  end

  // Next-state and output logic
  always_comb begin
    state_n   = state;
    ptr_n     = ptr;
    cnt_n     = cnt;
    gnt_n     = gnt;
    gnt_id_n  = gnt_id;
    busy_n    = busy;
    timeout_n = 1'b0;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          state_n  = OWNED;
          gnt_n    = N'(1) << pick_idx;
          gnt_id_n = pick_idx;
          busy_n   = 1'b1;
          cnt_n    = '0;
        end
      end
      OWNED: begin
        if (release_c) begin
          ptr_n     = ptr_inc;
          timeout_n = at_limit && !owner_done && !owner_drop;
          cnt_n     = '0;
          if (pick_valid) begin
            gnt_n    = N'(1) << pick_idx;
            gnt_id_n = pick_idx;
          end else begin
            state_n = IDLE;
            gnt_n   = '0;
            busy_n  = 1'b0;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: begin
        state_n = IDLE;
        gnt_n   = '0;
        busy_n  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= '0;
      cnt     <= '0;
      gnt     <= '0;
      gnt_id  <= '0;
      busy    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state   <= state_n;
      ptr     <= ptr_n;
      cnt     <= cnt_n;
      gnt     <= gnt_n;
      gnt_id  <= gnt_id_n;
      busy    <= busy_n;
      timeout <= timeout_n;
    end
  end

endmodule

// File: tb/tb_rr_lock_arbiter.sv
// Directed bench for rr_lock_arbiter (N=4, MAX_HOLD=4) with hand-computed grant sequences.
module tb_rr_lock_arbiter;

  localparam int unsigned N        = 4;
  localparam int unsigned MAX_HOLD = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] done;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       busy;
  logic       timeout;

  int tests  = 0;
  int errors = 0;

  rr_lock_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .done    (done),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .busy    (busy),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic [3:0] eg, input logic eb, input logic et);
    chk({tag, ".gnt"}, 32'(gnt), 32'(eg));
    chk({tag, ".busy"}, 32'(busy), 32'(eb));
    chk({tag, ".timeout"}, 32'(timeout), 32'(et));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] rot [5];
    rot[0] = 4'b0001; rot[1] = 4'b0010; rot[2] = 4'b0100; rot[3] = 4'b1000; rot[4] = 4'b0001;

    // Reset then idle
    rst = 1'b1; req = '0; done = '0;
    tick(); chk_state("rst0", 4'b0000, 1'b0, 1'b0);
    tick(); chk_state("rst1", 4'b0000, 1'b0, 1'b0);
    rst = 1'b0;
    tick(); chk_state("idle", 4'b0000, 1'b0, 1'b0);

    // Single owner for three cycles, released with done and request drop
    req = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      tick(); chk_state($sformatf("single%0d", i), 4'b0010, 1'b1, 1'b0);
    end
    chk("single.id", 32'(gnt_id), 32'd1);
    req = 4'b0000; done = 4'b0010;
    tick(); chk_state("single.rel", 4'b0000, 1'b0, 1'b0);
    done = '0;

    // Rotation with zero-bubble handoff (reset first so ptr starts at 0)
    rst = 1'b1; tick(); rst = 1'b0;
    req = 4'b1111;
    tick(); chk("rot0.gnt", 32'(gnt), 32'(rot[0]));
    done = 4'b1111;
    for (int i = 1; i < 5; i++) begin
      tick();
      chk($sformatf("rot%0d.gnt", i), 32'(gnt), 32'(rot[i]));
      chk($sformatf("rot%0d.id", i), 32'(gnt_id), 32'(i % 4));
    end
    req = '0; done = '0;
    tick(); chk_state("rot.idle", 4'b0000, 1'b0, 1'b0);

    // Hold limit: ptr is now 1, so req=0101 starts at requester 2
    req = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      tick(); chk_state($sformatf("hold_a%0d", i), 4'b0100, 1'b1, 1'b0);
    end
    tick(); chk_state("hold_b0", 4'b0001, 1'b1, 1'b1);
    for (int i = 1; i < 4; i++) begin
      tick(); chk_state($sformatf("hold_b%0d", i), 4'b0001, 1'b1, 1'b0);
    end
    tick(); chk_state("hold_c0", 4'b0100, 1'b1, 1'b1);

    // Non-owner done ignored, then owner drops request
    done = 4'b1011;
    tick(); chk_state("nonown", 4'b0100, 1'b1, 1'b0);
    done = '0; req = 4'b1001;
    tick(); chk_state("drop", 4'b1000, 1'b1, 1'b0);
    chk("drop.id", 32'(gnt_id), 32'd3);

    // Reset mid-grant at hold count 2
    tick(); tick(); chk_state("pre_rst", 4'b1000, 1'b1, 1'b0);
    rst = 1'b1;
    tick(); chk_state("mid_rst", 4'b0000, 1'b0, 1'b0);
    rst = 1'b0; req = 4'b1111;
    tick(); chk_state("post_rst", 4'b0001, 1'b1, 1'b0);

    // done coinciding with the hold limit: normal release, no timeout
    tick(); tick(); tick(); chk_state("lim3", 4'b0001, 1'b1, 1'b0);
    done = 4'b0001;
    tick(); chk_state("lim_done", 4'b0010, 1'b1, 1'b0);
    done = '0;

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
